// File: rtl/fb_pkg.sv
// Framebuffer geometry, colour codes and plot-sink types
// shared by the draw datapaths and the framebuffer sink.
package fb_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_ADDR_W = 15;
   localparam int COLOUR_W  = 3;

   localparam logic [COLOUR_W-1:0] COL_BLACK    = 3'd0;
   localparam logic [COLOUR_W-1:0] COL_OBSTACLE = 3'd2;
   localparam logic [COLOUR_W-1:0] COL_PLAYER   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_CMP,
      S_WR
   } state_t;

   typedef struct packed {
      logic [7:0]          x;
      logic [6:0]          y;
      logic [COLOUR_W-1:0] colour;
   } plot_t;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding pending plot requests.
// Pointers carry one wrap bit to tell full from empty.
module plot_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) &&
                    (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/plot_collision_sink.sv
// Plot stream sink: buffers plots, read-modify-writes the
// framebuffer and latches the first non-black overdraw.
module plot_collision_sink
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = 160,
   parameter int X_MAX      = 159,
   parameter int Y_MAX      = 119
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 plot_valid,
   output logic                 plot_ready,
   input  logic [7:0]           x,
   input  logic [6:0]           y,
   input  logic [COLOUR_W-1:0]  colour,
   output logic [FB_ADDR_W-1:0] mem_addr,
   output logic                 mem_rd_en,
   input  logic [COLOUR_W-1:0]  mem_rdata,
   output logic                 mem_wr_en,
   output logic [COLOUR_W-1:0]  mem_wdata,
   input  logic                 clear_collision,
   output logic                 collision,
   output logic [7:0]           collision_x,
   output logic [6:0]           collision_y,
   output logic [7:0]           oob_count,
   output logic                 busy
);

   localparam logic [7:0] XM = 8'(X_MAX);
   localparam logic [6:0] YM = 7'(Y_MAX);
   localparam logic [FB_ADDR_W-1:0] STRIDE =
      FB_ADDR_W'(SCREEN_W);

   state_t                 state;
   plot_t                  head;
   plot_t                  cur;
   plot_t                  in_plot;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   oob;
   logic                   hit;
   logic [FB_ADDR_W-1:0]   head_addr;

   assign in_plot = '{x: x, y: y, colour: colour};
   assign plot_ready = resetn && !full;
   assign pop  = (state == S_IDLE) && !empty;
   assign busy = !empty || (state != S_IDLE);
   assign oob  = (head.x > XM) || (head.y > YM);

   // Constant stride, so this reduces to (y<<7)+(y<<5)+x.
   assign head_addr = STRIDE * FB_ADDR_W'(head.y) +
                      FB_ADDR_W'(head.x);

   assign hit = (cur.colour != COL_BLACK) &&
                (mem_rdata != COL_BLACK) &&
                (mem_rdata != cur.colour);

   plot_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(plot_t))
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (plot_valid),
      .wdata  (in_plot),
      .pop    (pop),
      .rdata  (head),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         cur         <= '0;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wdata   <= '0;
         collision   <= 1'b0;
         collision_x <= '0;
         collision_y <= '0;
         oob_count   <= '0;
      end else begin
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         if (clear_collision) begin
            collision   <= 1'b0;
            collision_x <= '0;
            collision_y <= '0;
         end
         unique case (state)
            S_IDLE: begin
               if (!empty) begin
                  cur <= head;
                  if (oob) begin
                     if (oob_count != 8'hFF)
                        oob_count <= oob_count + 8'd1;
                  end else begin
                     mem_addr  <= head_addr;
                     mem_rd_en <= 1'b1;
                     state     <= S_RD;
                  end
               end
            end
            S_RD: state <= S_CMP;
            S_CMP: begin
               // A set in the clearing cycle overrides the clear.
               if (hit && (!collision || clear_collision)) begin
                  collision   <= 1'b1;
                  collision_x <= cur.x;
                  collision_y <= cur.y;
               end
               mem_wr_en <= 1'b1;
               mem_wdata <= cur.colour;
               state     <= S_WR;
            end
            S_WR: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/plot_collision_sink.md
Name: plot_collision_sink

Overview:
Receiving end of the pixel-plot stream that the draw datapaths emit as (x, y, colour, plot).
- Buffers plot requests in a small FIFO.
- Performs a read-modify-write of each pixel into the single-port 160x120 3-bit framebuffer RAM.
- Flags a sticky collision when a non-black pixel overwrites a different non-black pixel.
- Sits between the obstacle/player draw datapaths and the framebuffer; the game FSM polls and clears the collision flag.

Parameters:
FIFO_DEPTH, 4, plot entries buffered; power of two, at least 2
SCREEN_W, 160, pixels per row; also the address stride
X_MAX, 159, largest legal x
Y_MAX, 119, largest legal y

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous, active-low reset
plot_valid  in  1  plot request present
plot_ready  out  1  sink can accept; a transfer occurs when valid && ready on a rising edge
x  in  8  pixel column
y  in  7  pixel row
colour  in  3  pixel colour; 0 = black (erase)
mem_addr  out  15  framebuffer address = y*SCREEN_W + x
mem_rd_en  out  1  read strobe; mem_rdata is valid the cycle after
mem_rdata  in  3  framebuffer read data
mem_wr_en  out  1  write strobe
mem_wdata  out  3  write data
clear_collision  in  1  clears collision, collision_x and collision_y
collision  out  1  sticky collision flag
collision_x  out  8  x of the first collision since clear
collision_y  out  7  y of the first collision since clear
oob_count  out  8  saturating count of dropped out-of-range plots
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (async, resetn=0):
  - FIFO empty; FSM to IDLE.
  - mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - collision=0, collision_x=0, collision_y=0, oob_count=0, busy=0, plot_ready=0 while in reset.
  - Any in-flight pixel is lost; no partial write completes after reset asserts.
- plot_ready = !fifo_full.
  - A push in the same cycle as a pop while full is refused; the producer must hold valid.
  - x, y and colour are stored together.
- FSM states IDLE, RD, CMP, WR:
  - IDLE: if the FIFO is non-empty, pop the head into working registers.
    - Out of range (x>X_MAX or y>Y_MAX): increment oob_count (saturate at 255) and stay in IDLE; no memory access.
    - Otherwise go to RD.
  - RD: mem_rd_en=1, mem_addr = (y<<7)+(y<<5)+x, computed in 15 bits with no overflow. Go to CMP.
  - CMP: sample mem_rdata into old. Collision condition: colour!=0, old!=0, old!=colour. Go to WR.
  - WR: mem_wr_en=1, mem_wdata=colour, same mem_addr. Go to IDLE.
- mem_rd_en and mem_wr_en are registered; they are never both high in one cycle.
- Timing:
  - Plot accepted on edge 0 → pop at edge 1 → mem_rd_en high in cycle 2 → mem_wr_en high in cycle 4.
  - Steady-state throughput is 1 pixel per 4 cycles.
- Collision flag:
  - On the condition in CMP with collision=0: set collision and latch collision_x/collision_y at the WR transition.
  - If already set, the coordinates are held.
  - clear_collision clears all three; if a set occurs in the same cycle, the set wins and latches the new coordinates.
- Erase plots (colour=0) always write and never set collision.
- Writes of an equal colour are still performed.
- busy deasserts the cycle after WR when the FIFO is empty.

Decomposition:
- Shared package fb_pkg:
  - SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15, COLOUR_W=3.
  - Colour constants: COL_BLACK=3'd0, COL_OBSTACLE=3'd2, COL_PLAYER=3'd4.
  - FSM state encoding for this block.
- Sub-module plot_fifo:
  - Synchronous FIFO, width 18 (x, y, colour), depth FIFO_DEPTH.
  - Outputs full and empty; asynchronous active-low reset.

Test Plan:
- Reset mid-operation: plot (10,58,2) accepted, resetn pulsed low in the CMP cycle → no mem_wr_en pulse follows, busy=0, oob_count=0, collision=0.
- Single plot into empty RAM: plot (10,58,2) → mem_rd_en in cycle 2 with addr 9290, mem_wr_en in cycle 4 with wdata=2, collision stays 0.
- Overlap: RAM[9290]=4, plot (10,58,2) → collision=1, collision_x=10, collision_y=58. A later collision at (20,30) leaves the coordinates unchanged. clear_collision → all zero.
- Erase and equal colour: RAM[0]=2, plot (0,0,0), then RAM[5]=2, plot (5,0,2) → both written, collision=0.
- Backpressure: 6 back-to-back plots with FIFO_DEPTH=4 → plot_ready drops after the 4th+pop, all 6 written in order, busy low after the last WR.
- Out of range: plots (160,0,2) and (0,120,2) → no mem strobes, oob_count=2. Then 300 OOB plots → oob_count saturates at 255.
